// File: rtl/regfile_dump_tx_pkg.sv
// Shared types and constants for the register-file dump transmitter.
// PARITY_EN selects an 8E1 frame (11 bit times) instead of 8N1 (10 bit times).
package regfile_dump_tx_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 3;

`ifdef PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        DMP_IDLE = 3'd0,
        DMP_LOAD = 3'd1,
        DMP_SEND = 3'd2,
        DMP_DONE = 3'd3
    } dump_state_t;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
`ifdef PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/regfile_dump_tx_if.sv
// Register-file read port plus serial/status signals of the dump transmitter.
interface regfile_dump_tx_if;
    import regfile_dump_tx_pkg::*;

    logic              start;
    logic [DATA_W-1:0] q;
    logic [SEL_W-1:0]  rsel;
    logic              txd;
    logic              busy;
    logic              done;

    modport master (input start, input q, output rsel, output txd, output busy, output done);
    modport slave  (output start, output q, input rsel, input txd, input busy, input done);
endinterface

// File: rtl/uart_tx_byte.sv
// Serialises one captured byte as a UART frame; frame_done_c marks the last stop-bit cycle.
// PARITY_EN inserts an even-parity bit between the data and stop bits.
module uart_tx_byte
    import regfile_dump_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    output logic              txd,
    output logic              frame_done_c
);

    localparam int unsigned      BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t         state, state_nxt;
    logic [BAUD_W-1:0] baud, baud_nxt;
    logic [2:0]        bit_idx, bit_nxt;
    logic [DATA_W-1:0] shadow, shadow_nxt;
    logic              txd_nxt;
    logic              baud_end;

    assign baud_end = (baud == BAUD_LAST);

    // Next-state, counters and the registered line level for the next cycle.
    always_comb begin
        state_nxt    = state;
        baud_nxt     = baud;
        bit_nxt      = bit_idx;
        shadow_nxt   = shadow;
        frame_done_c = 1'b0;
        txd_nxt      = IDLE_LEVEL;

        if (state != TX_IDLE) begin
            baud_nxt = baud_end ? '0 : baud + BAUD_W'(1);
        end

        case (state)
            TX_IDLE: begin
                if (load) begin
                    shadow_nxt = data;
                    baud_nxt   = '0;
                    bit_nxt    = '0;
                    state_nxt  = TX_START;
                end
            end
            TX_START: if (baud_end) state_nxt = TX_DATA;
            TX_DATA: begin
                if (baud_end) begin
                    bit_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef PARITY_EN
                        state_nxt = TX_PARITY;
`else
                        state_nxt = TX_STOP;
`endif
                    end
                end
            end
`ifdef PARITY_EN
            TX_PARITY: if (baud_end) state_nxt = TX_STOP;
`endif
            TX_STOP: begin
                if (baud_end) begin
                    state_nxt    = TX_IDLE;
                    frame_done_c = 1'b1;
                end
            end
            default: state_nxt = TX_IDLE;
        endcase

        case (state_nxt)
            TX_START:  txd_nxt = 1'b0;
            TX_DATA:   txd_nxt = shadow_nxt[bit_nxt];
`ifdef PARITY_EN
            TX_PARITY: txd_nxt = ^shadow_nxt;
`endif
            default:   txd_nxt = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= TX_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shadow  <= '0;
            txd     <= IDLE_LEVEL;
        end else begin
            state   <= state_nxt;
            baud    <= baud_nxt;
            bit_idx <= bit_nxt;
            shadow  <= shadow_nxt;
            txd     <= txd_nxt;
        end
    end

endmodule

// File: rtl/regfile_dump_tx.sv
// Walks rsel over registers 0..NUM_REGS-1 and sends each byte out through uart_tx_byte.
// Frame format follows PARITY_EN (see regfile_dump_tx_pkg).
module regfile_dump_tx
    import regfile_dump_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned NUM_REGS     = 8
) (
    input  logic                      clk,
    input  logic                      clr,
    regfile_dump_tx_if.master         bus
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

    dump_state_t      state, state_nxt;
    logic [SEL_W-1:0] idx, idx_nxt;
    logic [SEL_W-1:0] rsel_r, rsel_nxt;
    logic             busy_r, done_r;
    logic             load_c;
    logic             frame_done_c;
    logic             tx_line;

    // Register sequencing: capture in LOAD, advance rsel after each stop bit.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        rsel_nxt  = rsel_r;
        load_c    = 1'b0;

        case (state)
            DMP_IDLE: begin
                if (bus.start) begin
                    state_nxt = DMP_LOAD;
                    idx_nxt   = '0;
                    rsel_nxt  = '0;
                end
            end
            DMP_LOAD: begin
                load_c    = 1'b1;
                state_nxt = DMP_SEND;
            end
            DMP_SEND: begin
                if (frame_done_c) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = DMP_DONE;
                    end else begin
                        idx_nxt   = idx + SEL_W'(1);
                        rsel_nxt  = idx + SEL_W'(1);
                        state_nxt = DMP_LOAD;
                    end
                end
            end
            DMP_DONE: begin
                state_nxt = DMP_IDLE;
                rsel_nxt  = '0;
            end
            default: state_nxt = DMP_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= DMP_IDLE;
            idx    <= '0;
            rsel_r <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            rsel_r <= rsel_nxt;
            busy_r <= (state_nxt != DMP_IDLE);
            done_r <= (state_nxt == DMP_DONE);
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk          (clk),
        .clr          (clr),
        .load         (load_c),
        .data         (bus.q),
        .txd          (tx_line),
        .frame_done_c (frame_done_c)
    );

    assign bus.rsel = rsel_r;
    assign bus.txd  = tx_line;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule
